// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the digit counter for n digits.
   // The result is never below 1, so a single-digit configuration
   // still has a legal counter vector.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells.
// Bit 0 takes br_in; every cell passes its borrow to the next higher bit.
module sub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             br_in,
   output logic [DIGIT-1:0] d,
   output logic             br_out
);

   logic [DIGIT:0] br;

   assign br[0] = br_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      assign d[i]    = a[i] ^ b[i] ^ br[i];
      assign br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i]);
   end

   assign br_out = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; diff/bout/ovf hold the last result
//   RUN   | one digit per cycle, least significant first; borrow registered
//   DONE  | result complete; done pulses for this single cycle
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(N);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q;
   state_t           state_d;

   // Operand copies shift right one digit per RUN cycle so the active
   // digit always sits in the low DIGIT bits feeding the digit cell.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   // Sign bits of the captured operands, kept for the overflow decision
   // after the shift registers have moved them out.
   logic             a_msb_q;
   logic             b_msb_q;
   logic             br_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DIGIT-1:0] dig_d;
   logic             dig_br;
   logic             accept;
   logic             last;

   sub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a      (a_q[DIGIT-1:0]),
      .b      (b_q[DIGIT-1:0]),
      .br_in  (br_q),
      .d      (dig_d),
      .br_out (dig_br)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      last    = (cnt_q == CNT_LAST);
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture, digit processing and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
         br_q    <= bin;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         a_q                        <= a_q >> DIGIT;
         b_q                        <= b_q >> DIGIT;
         br_q                       <= dig_br;
         cnt_q                      <= cnt_q + CNT_ONE;
         diff[cnt_q*DIGIT +: DIGIT] <= dig_d;
         // The top bit of the final digit is diff's sign bit.
         if (last) begin
            bout <= dig_br;
            ovf  <= (a_msb_q != b_msb_q) && (dig_d[DIGIT-1] != a_msb_q);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: three instances (DIGIT = 1, 4, 8), directed vectors.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
      int         acc;
      int         lat;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       st   [3];
   logic [7:0] av   [3];
   logic [7:0] bv   [3];
   logic       biv  [3];
   logic       bsy  [3];
   logic       dn   [3];
   logic [7:0] df   [3];
   logic       bo   [3];
   logic       ov   [3];

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .bin(biv[0]),
      .busy(bsy[0]), .done(dn[0]), .diff(df[0]), .bout(bo[0]), .ovf(ov[0]));

   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]), .bin(biv[1]),
      .busy(bsy[1]), .done(dn[1]), .diff(df[1]), .bout(bo[1]), .ovf(ov[1]));

   serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]), .bin(biv[2]),
      .busy(bsy[2]), .done(dn[2]), .diff(df[2]), .bout(bo[2]), .ovf(ov[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int lat_of(input int k);
      case (k)
         0:       return 9;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic push_exp(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Present one operation for a single cycle; the expected result is queued
   // with the edge at which the DUT should accept it.
   task automatic op(input int k, input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                     input logic [7:0] ed, input logic eb, input logic eo, input bit push);
      exp_t e;
      @(negedge clk);
      st[k] = 1'b1; av[k] = ai; bv[k] = bi; biv[k] = bini;
      @(negedge clk);
      st[k] = 1'b0;
      e.diff = ed; e.bout = eb; e.ovf = eo; e.acc = cyc; e.lat = lat_of(k);
      if (push) push_exp(k, e);
   endtask

   task automatic wait_done(input int k);
      int n;
      n = 0;
      while (dn[k] !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (dn[k] !== 1'b1) chk($sformatf("done_timeout_%0d", k), 0, 1);
   endtask

   // Monitor: pops the oldest expectation whenever an instance pulses done.
   always @(negedge clk) begin
      exp_t e;
      bit   got;
      for (int k = 0; k < 3; k++) begin
         if (rst_n === 1'b1 && dn[k] === 1'b1) begin
            got = 1'b0;
            case (k)
               0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
               1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
               chk($sformatf("unexpected_done_%0d", k), 1, 0);
            end else begin
               chk($sformatf("diff_%0d", k), df[k], e.diff);
               chk($sformatf("bout_%0d", k), bo[k], e.bout);
               chk($sformatf("ovf_%0d", k), ov[k], e.ovf);
               chk($sformatf("latency_%0d", k), cyc - e.acc + 1, e.lat);
            end
         end
      end
   end

   initial begin
      int   n;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0; av[k] = '0; bv[k] = '0; biv[k] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bsy[0], 0);
      chk("rst_done", dn[0], 0);
      chk("rst_diff", df[0], 0);
      chk("rst_bout_ovf", {bo[0], ov[0]}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", bsy[0], 0);

      // basic subtraction; busy spans 9 cycles
      op(0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (bsy[0] === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 9);

      op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1); wait_done(0);
      op(0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1); wait_done(0);
      op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1); wait_done(0);
      op(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1); wait_done(0);
      op(0, 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1); wait_done(0);

      // start held high; operands change mid-RUN and belong to the second op,
      // which must be accepted N+2 edges after the first
      @(negedge clk);
      st[0] = 1'b1; av[0] = 8'hC3; bv[0] = 8'h41; biv[0] = 1'b0;
      @(negedge clk);
      e.diff = 8'h82; e.bout = 1'b0; e.ovf = 1'b0; e.acc = cyc; e.lat = 9;
      q0.push_back(e);
      e.diff = 8'hEF; e.bout = 1'b1; e.ovf = 1'b0; e.acc = cyc + 10; e.lat = 9;
      q0.push_back(e);
      repeat (3) @(negedge clk);
      av[0] = 8'h20; bv[0] = 8'h30; biv[0] = 1'b1;
      repeat (7) @(negedge clk);
      st[0] = 1'b0;
      wait_done(0);
      @(negedge clk);

      // reset during RUN cycle 4 aborts the op
      op(0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bsy[0], 0);
      chk("abort_done", dn[0], 0);
      chk("abort_diff", df[0], 0);
      chk("abort_bout_ovf", {bo[0], ov[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_idle_busy", bsy[0], 0);
      op(0, 8'h64, 8'h32, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1); wait_done(0);

      // wider digits
      op(1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b1); wait_done(1);
      op(1, 8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1); wait_done(1);
      op(2, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b1); wait_done(2);
      op(2, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1); wait_done(2);

      repeat (3) @(negedge clk);
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      chk("queue2_drained", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
